// File: rtl/alu_pkg.sv
// Shared opcodes, FSM states and sizing helpers for multicycle_alu.
// Optional feature macro: ALU_OVERFLOW_EN (see multicycle_alu).
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_CMP  = 4'b0111;
  localparam logic [3:0] ALU_MUL  = 4'b1000;
  localparam logic [3:0] ALU_DIVU = 4'b1001;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    ITER,
    DONE
  } state_t;

  // Iteration counter must hold WIDTH down to 1.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Shared shift-register pair and adder/subtractor for iterative
// unsigned MUL (shift-add) and DIVU (restoring), one step per cycle.
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             mode,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] m_q;
  logic             div_q;
  logic [WIDTH:0]   x;
  logic [WIDTH:0]   y;
  logic             cin;
  logic [WIDTH+1:0] s;

  // One adder: hi+m (mul) or {hi,lo_msb}-m (div); s[WIDTH+1] is no-borrow.
  always_comb begin
    x   = '0;
    y   = '0;
    cin = 1'b0;
    if (div_q) begin
      x   = {hi_q, lo_q[WIDTH-1]};
      y   = ~{1'b0, m_q};
      cin = 1'b1;
    end else begin
      x = {1'b0, hi_q};
      y = lo_q[0] ? {1'b0, m_q} : '0;
    end
    s = {1'b0, x} + {1'b0, y} + (WIDTH+2)'(cin);
  end

  // Operand load and per-step shift of the hi/lo pair.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q  <= '0;
      lo_q  <= '0;
      m_q   <= '0;
      div_q <= 1'b0;
    end else if (load) begin
      hi_q  <= '0;
      lo_q  <= a;
      m_q   <= b;
      div_q <= mode;
    end else if (step) begin
      if (div_q) begin
        hi_q <= s[WIDTH+1] ? s[WIDTH-1:0] : x[WIDTH-1:0];
        lo_q <= {lo_q[WIDTH-2:0], s[WIDTH+1]};
      end else begin
        hi_q <= s[WIDTH:1];
        lo_q <= {s[0], lo_q[WIDTH-1:1]};
      end
    end
  end

  assign lo = lo_q;
  assign hi = hi_q;

endmodule

// File: rtl/multicycle_alu.sv
// Registered ALU with start/done handshake; MUL/DIVU iterate WIDTH steps.
// Define ALU_OVERFLOW_EN to add the signed-overflow output.
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OP_W  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             illegal
`ifdef ALU_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic             is_and;
  logic             is_or;
  logic             is_add;
  logic             is_sub;
  logic             is_cmp;
  logic             is_mul;
  logic             is_div;
  logic             launch;
  logic             launch_it;
  logic             launch_1;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ill;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] hi_q;
  logic             zero_q;
  logic             ill_q;
  logic [WIDTH-1:0] iter_lo;
  logic [WIDTH-1:0] iter_hi;

  assign is_and = op == OP_W'(ALU_AND);
  assign is_or  = op == OP_W'(ALU_OR);
  assign is_add = op == OP_W'(ALU_ADD);
  assign is_sub = op == OP_W'(ALU_SUB);
  assign is_cmp = op == OP_W'(ALU_CMP);
  assign is_mul = op == OP_W'(ALU_MUL);
  assign is_div = op == OP_W'(ALU_DIVU);

  // New work is accepted in every state but ITER, incl. the done cycle.
  assign launch    = start && (state != ITER);
  assign launch_it = launch && (is_mul || is_div);
  assign launch_1  = launch && !(is_mul || is_div);

  assign sum  = in1 + in2;
  assign diff = in1 - in2;

  // Single-cycle datapath; undefined opcodes raise illegal.
  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    unique case (1'b1)
      is_and:         alu_res = in1 & in2;
      is_or:          alu_res = in1 | in2;
      is_add:         alu_res = sum;
      is_sub, is_cmp: alu_res = diff;
      is_mul, is_div: alu_res = '0;
      default:        alu_ill = 1'b1;
    endcase
  end

  muldiv_iter #(
    .WIDTH(WIDTH)
  ) u_iter (
    .clk  (clk),
    .reset(reset),
    .load (launch_it),
    .mode (is_div),
    .step (state == ITER),
    .a    (in1),
    .b    (in2),
    .lo   (iter_lo),
    .hi   (iter_hi)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state: EXEC/DONE are the done-pulse cycles and accept start.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, EXEC, DONE: begin
        if (launch_it)     state_nxt = ITER;
        else if (launch_1) state_nxt = EXEC;
        else               state_nxt = IDLE;
      end
      ITER: if (cnt == CW'(1)) state_nxt = DONE;
    endcase
  end

  // Step counter: WIDTH down to 1 while iterating.
  always_ff @(posedge clk) begin
    if (reset)             cnt <= '0;
    else if (launch_it)    cnt <= CW'(WIDTH);
    else if (state == ITER) cnt <= cnt - CW'(1);
  end

  // Held results: written by a 1-cycle launch, or from the iterator
  // as the DONE cycle ends (a 1-cycle launch then takes priority).
  always_ff @(posedge clk) begin
    if (reset) begin
      res_q  <= '0;
      hi_q   <= '0;
      zero_q <= 1'b0;
      ill_q  <= 1'b0;
    end else if (launch_1) begin
      res_q  <= alu_res;
      hi_q   <= '0;
      zero_q <= !alu_ill && (alu_res == '0);
      ill_q  <= alu_ill;
    end else if (state == DONE) begin
      res_q  <= iter_lo;
      hi_q   <= iter_hi;
      zero_q <= iter_lo == '0;
      ill_q  <= 1'b0;
    end
  end

  assign busy      = state == ITER;
  assign done      = (state == EXEC) || (state == DONE);
  assign result    = (state == DONE) ? iter_lo : res_q;
  assign result_hi = (state == DONE) ? iter_hi : hi_q;
  assign zero      = (state == DONE) ? (iter_lo == '0) : zero_q;
  assign illegal   = (state == DONE) ? 1'b0 : ill_q;

`ifdef ALU_OVERFLOW_EN
  logic alu_ovf;
  logic ovf_q;

  // Signed overflow of ADD and SUB/CMP; zero for all other ops.
  always_comb begin
    alu_ovf = 1'b0;
    if (is_add)
      alu_ovf = (in1[WIDTH-1] == in2[WIDTH-1]) &&
                (sum[WIDTH-1] != in1[WIDTH-1]);
    else if (is_sub || is_cmp)
      alu_ovf = (in1[WIDTH-1] != in2[WIDTH-1]) &&
                (diff[WIDTH-1] != in1[WIDTH-1]);
  end

  // Overflow flag held alongside the result.
  always_ff @(posedge clk) begin
    if (reset)              ovf_q <= 1'b0;
    else if (launch_1)      ovf_q <= alu_ovf;
    else if (state == DONE) ovf_q <= 1'b0;
  end

  assign overflow = (state == DONE) ? 1'b0 : ovf_q;
`endif

endmodule

// File: tb/tb_multicycle_alu.sv
// Scoreboard bench for multicycle_alu (WIDTH=32).
// Reference model uses plain arithmetic; monitor checks every cycle.
module tb_multicycle_alu;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  op = '0;
  logic [31:0] in1 = '0;
  logic [31:0] in2 = '0;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [31:0] result_hi;
  logic        zero;
  logic        illegal;
`ifdef ALU_OVERFLOW_EN
  logic        overflow;
`endif

  multicycle_alu #(
    .WIDTH(32),
    .OP_W (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .in1      (in1),
    .in2      (in2),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .result_hi(result_hi),
    .zero     (zero),
    .illegal  (illegal)
`ifdef ALU_OVERFLOW_EN
    ,
    .overflow (overflow)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [31:0] hi;
    logic        zero;
    logic        ill;
    logic        ovf;
    int          due;
  } exp_t;

  exp_t q[$];
  exp_t last;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)",
               nm, act, req, cyc);
    end
  endtask

  function automatic exp_t model(input logic [3:0] o,
                                 input logic [31:0] a,
                                 input logic [31:0] b);
    exp_t        e;
    longint      sa;
    longint      sb;
    longint      r;
    logic [63:0] p;
    e.res = '0;
    e.hi  = '0;
    e.ill = 1'b0;
    e.ovf = 1'b0;
    e.due = 0;
    sa = $signed(a);
    sb = $signed(b);
    case (o)
      4'h0: e.res = a & b;
      4'h1: e.res = a | b;
      4'h2: begin
        e.res = a + b;
        r     = sa + sb;
        e.ovf = r != longint'($signed(e.res));
      end
      4'h6, 4'h7: begin
        e.res = a - b;
        r     = sa - sb;
        e.ovf = r != longint'($signed(e.res));
      end
      4'h8: begin
        p     = {32'h0, a} * {32'h0, b};
        e.res = p[31:0];
        e.hi  = p[63:32];
      end
      4'h9: begin
        if (b == 0) begin
          e.res = 32'hFFFF_FFFF;
          e.hi  = a;
        end else begin
          e.res = a / b;
          e.hi  = a % b;
        end
      end
      default: e.ill = 1'b1;
    endcase
    e.zero = !e.ill && (e.res == 0);
    return e;
  endfunction

  // Monitor: samples 1 time unit after each rising edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (reset) begin
      q.delete();
      last = '{res: 0, hi: 0, zero: 0, ill: 0, ovf: 0, due: 0};
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_result", result, 0);
      chk("rst_result_hi", result_hi, 0);
      chk("rst_zero", zero, 0);
      chk("rst_illegal", illegal, 0);
`ifdef ALU_OVERFLOW_EN
      chk("rst_overflow", overflow, 0);
`endif
    end else if (done) begin
      chk("done_busy", busy, 0);
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_done actual=1 required=0 (cycle %0d)", cyc);
      end else begin
        e = q.pop_front();
        chk("latency_cycle", cyc, e.due);
        chk("result", result, e.res);
        chk("result_hi", result_hi, e.hi);
        chk("zero", zero, e.zero);
        chk("illegal", illegal, e.ill);
`ifdef ALU_OVERFLOW_EN
        chk("overflow", overflow, e.ovf);
`endif
        last = e;
      end
    end else begin
      chk("busy", busy, q.size() != 0);
      chk("hold_result", result, last.res);
      chk("hold_result_hi", result_hi, last.hi);
      chk("hold_zero", zero, last.zero);
      chk("hold_illegal", illegal, last.ill);
`ifdef ALU_OVERFLOW_EN
      chk("hold_overflow", overflow, last.ovf);
`endif
      if (q.size() != 0 && cyc > q[0].due) begin
        checks++;
        failures++;
        $display("FAIL done_late actual=none required=%0d", q[0].due);
        void'(q.pop_front());
      end
    end
  end

  // Driver: called at a falling edge; junk starts while busy.
  task automatic issue(input logic [3:0] o, input logic [31:0] a,
                       input logic [31:0] b);
    exp_t e;
    int   g;
    g = 0;
    while (busy === 1'b1 && g < 80) begin
      start = ($urandom_range(0, 2) == 0);
      op    = 4'($urandom);
      in1   = $urandom;
      in2   = $urandom;
      @(negedge clk);
      g++;
    end
    if (g >= 80) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=busy required=idle");
    end
    start = 1'b1;
    op    = o;
    in1   = a;
    in2   = b;
    e     = model(o, a, b);
    e.due = cyc + ((o == 4'h8 || o == 4'h9) ? 33 : 1);
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    op    = 4'($urandom);
    in1   = $urandom;
    in2   = $urandom;
  endtask

  function automatic logic [3:0] pick_op();
    logic [3:0] defs [7];
    logic [3:0] o;
    defs = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'h8, 4'h9};
    if ($urandom_range(0, 9) < 8) return defs[$urandom_range(0, 6)];
    o = 4'h5;
    for (int i = 0; i < 16; i++) begin
      o = 4'($urandom);
      if (!(o inside {4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'h8, 4'h9}))
        break;
    end
    if (o inside {4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'h8, 4'h9}) o = 4'h5;
    return o;
  endfunction

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 5))
      0:       return 32'($urandom_range(0, 15));
      1:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
      2:       return 32'h8000_0000 ^ 32'($urandom_range(0, 3));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    int          g;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    issue(4'h0, 32'h1234_1234, 32'h1234_1234);
    issue(4'h1, 32'h1234_1234, 32'h1234_1234);
    issue(4'h2, 32'h1234_1234, 32'h1234_1234);
    issue(4'h6, 32'h1234_1234, 32'h1234_1234);
    issue(4'h7, 32'd5, 32'd5);
    issue(4'h7, 32'd5, 32'd6);
    issue(4'h8, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(4'h9, 32'd100, 32'd7);
    issue(4'h9, 32'd9, 32'd0);
    issue(4'h5, 32'hDEAD_BEEF, 32'h1);
    issue(4'h2, 32'h7FFF_FFFF, 32'h1);
    issue(4'h6, 32'h8000_0000, 32'h1);

    issue(4'h8, 32'h0001_0003, 32'h0000_0101);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    issue(4'h9, 32'hFFFF_FFFF, 32'd10);
    issue(4'h2, 32'h0, 32'h0);

    for (int n = 0; n < 150; n++) begin
      a = pick_val();
      b = pick_val();
      issue(pick_op(), a, b);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    g = 0;
    while (q.size() != 0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    repeat (2) @(negedge clk);
    chk("drain_pending", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
